// File: rtl/cluster_ce_pipe.sv
// Two-stage compare-exchange node for the k-d tree cluster sorter.
// Orders {left, parent, right} along the split axis and tracks swap-free stability.
module cluster_ce_pipe #(
  parameter int unsigned DIM        = 3,
  parameter int unsigned DIM_W      = 8,
  parameter int unsigned STABLE_CNT = 4,
  localparam int unsigned CW        = DIM * DIM_W,
  localparam int unsigned AW        = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          sorting,
  input  logic          left_en,
  input  logic          right_en,
  input  logic [CW-1:0] left,
  input  logic [CW-1:0] parent,
  input  logic [CW-1:0] right,
  input  logic [AW-1:0] axis,
  input  logic          clr_stable,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] new_left,
  output logic [CW-1:0] new_parent,
  output logic [CW-1:0] new_right,
  output logic          left_switch,
  output logic          parent_switch,
  output logic          right_switch,
  output logic [AW-1:0] child_axis,
  output logic          stable
);

  localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);
  localparam int unsigned TW    = 2;

  localparam logic [TW-1:0] TAG_L = TW'(0);
  localparam logic [TW-1:0] TAG_P = TW'(1);
  localparam logic [TW-1:0] TAG_R = TW'(2);

  // Whole pipeline moves together; a stalled output freezes both stages.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Out-of-range axes fall back to axis 0 for both the key and the child axis.
  logic [AW-1:0] ax_eff;
  logic [31:0]   key_lsb;
  logic [AW-1:0] cax_in;

  assign ax_eff  = (32'(axis) >= DIM) ? '0 : axis;
  assign key_lsb = 32'(ax_eff) * DIM_W;
  assign cax_in  = (32'(ax_eff) == (DIM - 1)) ? '0 : (ax_eff + AW'(1));

  logic [DIM_W-1:0] k_l, k_p, k_r;
  assign k_l = left[key_lsb +: DIM_W];
  assign k_p = parent[key_lsb +: DIM_W];
  assign k_r = right[key_lsb +: DIM_W];

  // Excluded or pass-through slots simply disable the compare-exchanges touching them.
  logic en_lp, en_pr;
  assign en_lp = sorting & left_en;
  assign en_pr = sorting & right_en;

  // First CE(L,P); ties keep input order.
  logic             sw1;
  logic [CW-1:0]    a_l, a_p;
  logic [DIM_W-1:0] ka_l, ka_p;
  logic [TW-1:0]    ta_l, ta_p;

  assign sw1  = en_lp & (k_l > k_p);
  assign a_l  = sw1 ? parent : left;
  assign a_p  = sw1 ? left   : parent;
  assign ka_l = sw1 ? k_p    : k_l;
  assign ka_p = sw1 ? k_l    : k_p;
  assign ta_l = sw1 ? TAG_P  : TAG_L;
  assign ta_p = sw1 ? TAG_L  : TAG_P;

  logic             s1_valid;
  logic [CW-1:0]    s1_l, s1_p, s1_r;
  logic [DIM_W-1:0] s1_kl, s1_kp, s1_kr;
  logic [TW-1:0]    s1_tl, s1_tp, s1_tr;
  logic             s1_en_lp, s1_en_pr;
  logic [AW-1:0]    s1_cax;

  // Stage 1 register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_l     <= '0;
      s1_p     <= '0;
      s1_r     <= '0;
      s1_kl    <= '0;
      s1_kp    <= '0;
      s1_kr    <= '0;
      s1_tl    <= '0;
      s1_tp    <= '0;
      s1_tr    <= '0;
      s1_en_lp <= 1'b0;
      s1_en_pr <= 1'b0;
      s1_cax   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_l     <= a_l;
      s1_p     <= a_p;
      s1_r     <= right;
      s1_kl    <= ka_l;
      s1_kp    <= ka_p;
      s1_kr    <= k_r;
      s1_tl    <= ta_l;
      s1_tp    <= ta_p;
      s1_tr    <= TAG_R;
      s1_en_lp <= en_lp;
      s1_en_pr <= en_pr;
      s1_cax   <= cax_in;
    end
  end

  // Second CE(P,R).
  logic             sw2;
  logic [CW-1:0]    m_p, m_r;
  logic [DIM_W-1:0] m_kp;
  logic [TW-1:0]    m_tp, m_tr;

  assign sw2  = s1_en_pr & (s1_kp > s1_kr);
  assign m_p  = sw2 ? s1_r  : s1_p;
  assign m_r  = sw2 ? s1_p  : s1_r;
  assign m_kp = sw2 ? s1_kr : s1_kp;
  assign m_tp = sw2 ? s1_tr : s1_tp;
  assign m_tr = sw2 ? s1_tp : s1_tr;

  // Final CE(L,P); with the right child excluded L/P are already ordered by CE1.
  logic          sw3;
  logic [CW-1:0] f_l, f_p;
  logic [TW-1:0] f_tl, f_tp;

  assign sw3  = s1_en_lp & (s1_kl > m_kp);
  assign f_l  = sw3 ? m_p   : s1_l;
  assign f_p  = sw3 ? s1_l  : m_p;
  assign f_tl = sw3 ? m_tp  : s1_tl;
  assign f_tp = sw3 ? s1_tl : m_tp;

  // Stage 2 / output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      new_left      <= '0;
      new_parent    <= '0;
      new_right     <= '0;
      left_switch   <= 1'b0;
      parent_switch <= 1'b0;
      right_switch  <= 1'b0;
      child_axis    <= '0;
    end else if (adv) begin
      out_valid     <= s1_valid;
      new_left      <= f_l;
      new_parent    <= f_p;
      new_right     <= m_r;
      left_switch   <= (f_tl != TAG_L);
      parent_switch <= (f_tp != TAG_P);
      right_switch  <= (m_tr != TAG_R);
      child_axis    <= s1_cax;
    end
  end

  // Swap-free counter; clear request wins over a same-cycle handshake.
  logic             hs;
  logic             any_sw;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  assign hs     = out_valid & out_ready;
  assign any_sw = left_switch | parent_switch | right_switch;

  always_comb begin
    cnt_nxt = cnt;
    if (clr_stable) begin
      cnt_nxt = '0;
    end else if (hs) begin
      if (any_sw) begin
        cnt_nxt = '0;
      end else if (cnt < CNT_W'(STABLE_CNT)) begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      stable <= (cnt_nxt >= CNT_W'(STABLE_CNT));
    end
  end

endmodule

// File: tb/tb_cluster_ce_pipe.sv
// Scoreboard bench for cluster_ce_pipe: a rank-based stable-sort model predicts each
// accepted triple; outputs are compared against the queue head every valid cycle.
module tb_cluster_ce_pipe;

  localparam int unsigned DIM        = 3;
  localparam int unsigned DIM_W      = 8;
  localparam int unsigned STABLE_CNT = 4;
  localparam int unsigned CW         = DIM * DIM_W;
  localparam int unsigned AW         = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          sorting;
  logic          left_en;
  logic          right_en;
  logic [CW-1:0] left;
  logic [CW-1:0] parent;
  logic [CW-1:0] right;
  logic [AW-1:0] axis;
  logic          clr_stable;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] new_left;
  logic [CW-1:0] new_parent;
  logic [CW-1:0] new_right;
  logic          left_switch;
  logic          parent_switch;
  logic          right_switch;
  logic [AW-1:0] child_axis;
  logic          stable;

  cluster_ce_pipe #(.DIM(DIM), .DIM_W(DIM_W), .STABLE_CNT(STABLE_CNT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sorting(sorting), .left_en(left_en), .right_en(right_en),
    .left(left), .parent(parent), .right(right), .axis(axis),
    .clr_stable(clr_stable), .out_valid(out_valid), .out_ready(out_ready),
    .new_left(new_left), .new_parent(new_parent), .new_right(new_right),
    .left_switch(left_switch), .parent_switch(parent_switch),
    .right_switch(right_switch), .child_axis(child_axis), .stable(stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] l;
    logic [CW-1:0] p;
    logic [CW-1:0] r;
    logic [2:0]    sw;   // {left, parent, right}
    logic [AW-1:0] cax;
  } exp_t;

  exp_t q[$];
  int   n_vec;
  int   n_err;
  int   mcnt;
  bit   acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stable ranking of the enabled slots, then placement into those slots in order.
  function automatic exp_t model(input logic srt, input logic le, input logic re,
                                 input logic [CW-1:0] l, input logic [CW-1:0] p,
                                 input logic [CW-1:0] r, input logic [AW-1:0] ax);
    logic [CW-1:0]    c[3];
    logic [CW-1:0]    o[3];
    logic [DIM_W-1:0] k[3];
    logic             en[3];
    int               idx[3];
    int               n;
    int               ae;
    int               rank;
    exp_t             e;
    c[0] = l; c[1] = p; c[2] = r;
    ae = (int'(ax) >= int'(DIM)) ? 0 : int'(ax);
    for (int i = 0; i < 3; i++) begin
      k[i] = c[i][ae*8 +: 8];
      o[i] = c[i];
    end
    en[0] = srt & le; en[1] = srt; en[2] = srt & re;
    e.sw = 3'b000;
    n = 0;
    for (int i = 0; i < 3; i++) if (en[i]) begin idx[n] = i; n++; end
    if (n >= 2) begin
      for (int i = 0; i < 3; i++) begin
        if (en[i]) begin
          rank = 0;
          for (int j = 0; j < 3; j++)
            if (en[j] && ((k[j] < k[i]) || (k[j] == k[i] && j < i))) rank++;
          o[idx[rank]] = c[i];
          e.sw[2-idx[rank]] = (i != idx[rank]);
        end
      end
    end
    e.l = o[0]; e.p = o[1]; e.r = o[2];
    e.cax = AW'((ae + 1) % int'(DIM));
    return e;
  endfunction

  // One clock: score the output/input handshakes of this cycle, then step the edge.
  task automatic tick();
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out", 64'(1), 64'(0));
      end else begin
        e = q[0];
        chk("new_left",   64'(new_left),   64'(e.l));
        chk("new_parent", 64'(new_parent), 64'(e.p));
        chk("new_right",  64'(new_right),  64'(e.r));
        chk("switches",   64'({left_switch, parent_switch, right_switch}), 64'(e.sw));
        chk("child_axis", 64'(child_axis), 64'(e.cax));
        if (out_ready) begin
          void'(q.pop_front());
          if (e.sw != 3'b000) mcnt = 0;
          else if (mcnt < int'(STABLE_CNT)) mcnt++;
        end
      end
    end
    if (clr_stable) mcnt = 0;
    if (acc) q.push_back(model(sorting, left_en, right_en, left, parent, right, axis));
    @(posedge clk);
    #1;
    if (rst) chk("stable", 64'(stable), 64'(mcnt >= int'(STABLE_CNT)));
  endtask

  function automatic logic [CW-1:0] ctr(input logic [7:0] b0);
    return {8'($urandom), 8'($urandom), b0};
  endfunction

  task automatic set_in(input logic srt, input logic le, input logic re,
                        input logic [CW-1:0] l, input logic [CW-1:0] p,
                        input logic [CW-1:0] r, input logic [AW-1:0] ax);
    sorting = srt; left_en = le; right_en = re;
    left = l; parent = p; right = r; axis = ax;
  endtask

  task automatic send(input logic srt, input logic le, input logic re,
                      input logic [7:0] l, input logic [7:0] p, input logic [7:0] r);
    int n;
    set_in(srt, le, re, ctr(l), ctr(p), ctr(r), 2'd0);
    in_valid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!acc && n < 20);
    if (!acc) chk("accept_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic send_raw(input logic [CW-1:0] l, input logic [CW-1:0] p,
                          input logic [CW-1:0] r, input logic [AW-1:0] ax);
    int n;
    set_in(1'b1, 1'b1, 1'b1, l, p, r, ax);
    in_valid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!acc && n < 20);
    if (!acc) chk("accept_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 20) begin tick(); n++; end
    if (q.size() > 0) chk("drain_timeout", 64'(q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    n_vec = 0; n_err = 0; mcnt = 0; acc = 1'b0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_stable = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'd0);
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_stable",    64'(stable),    64'(0));
    chk("rst_new_left",  64'(new_left),  64'(0));
    chk("rst_child_axis", 64'(child_axis), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Normal order and two-cycle latency
    send(1'b1, 1'b1, 1'b1, 8'd101, 8'd102, 8'd103);
    chk("lat_s1_invalid", 64'(out_valid), 64'(0));
    tick();
    chk("lat_s2_valid", 64'(out_valid), 64'(1));
    chk("normal_sw", 64'({left_switch, parent_switch, right_switch}), 64'(3'b000));
    drain();

    // Permutations, ties, partial children, pass-through
    send(1'b1, 1'b1, 1'b1, 8'd150, 8'd99,  8'd233);
    send(1'b1, 1'b1, 1'b1, 8'd5,   8'd1,   8'd3);
    send(1'b1, 1'b1, 1'b1, 8'd255, 8'd254, 8'd253);
    send(1'b1, 1'b1, 1'b1, 8'd50,  8'd150, 8'd60);
    send(1'b1, 1'b1, 1'b1, 8'd7,   8'd7,   8'd7);
    send(1'b1, 1'b0, 1'b1, 8'd200, 8'd50,  8'd10);
    send(1'b1, 1'b1, 1'b0, 8'd9,   8'd3,   8'd1);
    send(1'b1, 1'b0, 1'b0, 8'd9,   8'd3,   8'd1);
    send(1'b0, 1'b1, 1'b1, 8'd5,   8'd1,   8'd3);
    drain();

    // Axis selection: byte-2 keys, wrap of child axis, and out-of-range axis
    send_raw({8'd9, 8'd77, 8'd1}, {8'd4, 8'd66, 8'd2}, {8'd1, 8'd55, 8'd3}, 2'd2);
    send_raw(ctr(8'd30), ctr(8'd10), ctr(8'd20), 2'd3);
    send_raw({8'd1, 8'd40, 8'd3}, {8'd2, 8'd20, 8'd2}, {8'd3, 8'd30, 8'd1}, 2'd1);
    drain();

    // Backpressure mid-stream
    idx = 0;
    for (int cyc = 0; cyc < 40 && (idx < 4 || q.size() > 0); cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (idx < 4) begin
        set_in(1'b1, 1'b1, 1'b1, ctr(8'(10*idx + 3)), ctr(8'(10*idx + 1)),
               ctr(8'(10*idx + 2)), 2'd0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (cyc >= 3 && cyc <= 5) begin
        #1;
        chk("bp_in_ready", 64'(in_ready), 64'(0));
      end
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 64'(idx), 64'(4));
    chk("bp_left_over", 64'(q.size()), 64'(0));
    drain();

    // Stability counter
    clr_stable = 1'b1; tick(); clr_stable = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b1, 1'b1, 1'b1, 8'(20 + i), 8'(40 + i), 8'(60 + i));
    drain();
    chk("stable_after_4", 64'(stable), 64'(1));
    send(1'b1, 1'b1, 1'b1, 8'd9, 8'd5, 8'd7);
    drain();
    chk("stable_after_swap", 64'(stable), 64'(0));
    for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 1'b1, 8'd1, 8'd2, 8'd3);
    drain();
    chk("stable_after_3", 64'(stable), 64'(0));
    out_ready = 1'b0;
    send(1'b1, 1'b1, 1'b1, 8'd1, 8'd2, 8'd3);
    for (int n = 0; n < 5 && !out_valid; n++) tick();
    chk("clr_wait_valid", 64'(out_valid), 64'(1));
    clr_stable = 1'b1; out_ready = 1'b1;
    tick();
    clr_stable = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 1'b1, 8'd4, 8'd5, 8'd6);
    drain();
    chk("clr_priority", 64'(stable), 64'(0));
    send(1'b1, 1'b1, 1'b1, 8'd4, 8'd5, 8'd6);
    drain();
    chk("stable_again", 64'(stable), 64'(1));

    // Reset with two triples in flight
    send(1'b1, 1'b1, 1'b1, 8'd101, 8'd102, 8'd103);
    send(1'b1, 1'b1, 1'b1, 8'd150, 8'd99, 8'd233);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_stable",    64'(stable),    64'(0));
    chk("mid_rst_outputs",   64'({new_left, new_parent, new_right} != '0), 64'(0));
    chk("mid_rst_switches",  64'({left_switch, parent_switch, right_switch}), 64'(0));
    chk("mid_rst_child_axis", 64'(child_axis), 64'(0));
    chk("mid_rst_in_ready",  64'(in_ready),  64'(1));
    q.delete();
    mcnt = 0;
    tick();
    tick();
    chk("rst_held_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b1;
    send(1'b1, 1'b1, 1'b1, 8'd33, 8'd11, 8'd22);
    chk("post_rst_lat1", 64'(out_valid), 64'(0));
    tick();
    chk("post_rst_lat2", 64'(out_valid), 64'(1));
    drain();
    chk("final_queue_empty", 64'(q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
